// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder accuracy blocks:
// default operand width, sum/error-distance types and a saturating add.
package approx_pkg;

  localparam int AP_W = 8;

  typedef logic [AP_W:0] sum_t;
  typedef logic [AP_W:0] ed_t;

  // v + inc, clamped to the all-ones value of a w-bit field
  function automatic logic [63:0] sat_inc(input logic [63:0] v,
                                          input logic [63:0] inc,
                                          input int unsigned w);
    logic [64:0] s;
    logic [63:0] mx;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s  = {1'b0, v} + {1'b0, inc};
    if (s > {1'b0, mx}) return mx;
    else                return s[63:0];
  endfunction

endpackage

// File: rtl/approx_ed_calc.sv
// Combinational exact sum and absolute error distance against an
// approximate sum. Widths are W+1 so neither result can wrap.
module approx_ed_calc
  import approx_pkg::*;
#(
  parameter int W = AP_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W:0]   i_approx,
  output logic [W:0]   o_exact,
  output logic [W:0]   o_ed
);

  logic [W:0] w_exact;

  assign w_exact = {1'b0, i_a} + {1'b0, i_b};

  // subtract the smaller from the larger so the distance never underflows
  always_comb begin
    o_exact = w_exact;
    o_ed    = (w_exact >= i_approx) ? (w_exact - i_approx) : (i_approx - w_exact);
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Error monitor for an approximate adder: one-stage result register with
// valid/ready handshake plus saturating running statistics.
// Define APPROX_ERR_HIST_EN to add an 8-bin error-magnitude histogram
// (ports hist_sel / hist_cnt).
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int W     = AP_W,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_exact,
  output logic [W:0]       out_ed,
  output logic             out_err,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_n,
  output logic [CNT_W-1:0] stat_nerr,
  output logic [ACC_W-1:0] stat_sum_ed,
`ifdef APPROX_ERR_HIST_EN
  input  logic [2:0]       hist_sel,
  output logic [CNT_W-1:0] hist_cnt,
`endif
  output logic [W:0]       stat_max_ed
);

  logic [W:0]       w_exact, w_ed;
  logic             w_xfer;
  logic             r_ovld;
  logic [W:0]       r_exact, r_ed;
  logic             r_err;
  logic [CNT_W-1:0] r_n, r_nerr, w_n_base, w_nerr_base;
  logic [ACC_W-1:0] r_sum, w_sum_base;
  logic [W:0]       r_max, w_max_base;

  approx_ed_calc #(.W(W)) u_calc (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_approx (in_approx),
    .o_exact  (w_exact),
    .o_ed     (w_ed)
  );

  assign in_ready = ~r_ovld | out_ready;
  assign w_xfer   = in_valid & in_ready;

  // result register: reload on accept (even while draining), else drop when taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovld  <= 1'b0;
      r_exact <= '0;
      r_ed    <= '0;
      r_err   <= 1'b0;
    end else if (w_xfer) begin
      r_ovld  <= 1'b1;
      r_exact <= w_exact;
      r_ed    <= w_ed;
      r_err   <= (w_ed != '0);
    end else if (out_ready) begin
      r_ovld  <= 1'b0;
    end
  end

  assign out_valid = r_ovld;
  assign out_exact = r_exact;
  assign out_ed    = r_ed;
  assign out_err   = r_err;

  // a clear zeroes the base so a coincident sample starts the stats afresh
  assign w_n_base    = stat_clr ? '0 : r_n;
  assign w_nerr_base = stat_clr ? '0 : r_nerr;
  assign w_sum_base  = stat_clr ? '0 : r_sum;
  assign w_max_base  = stat_clr ? '0 : r_max;

  // running statistics, all saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n    <= '0;
      r_nerr <= '0;
      r_sum  <= '0;
      r_max  <= '0;
    end else if (w_xfer) begin
      r_n    <= CNT_W'(sat_inc(64'(w_n_base), 64'd1, CNT_W));
      r_nerr <= CNT_W'(sat_inc(64'(w_nerr_base), {63'd0, (w_ed != '0)}, CNT_W));
      r_sum  <= ACC_W'(sat_inc(64'(w_sum_base), 64'(w_ed), ACC_W));
      r_max  <= (w_ed > w_max_base) ? w_ed : w_max_base;
    end else begin
      r_n    <= w_n_base;
      r_nerr <= w_nerr_base;
      r_sum  <= w_sum_base;
      r_max  <= w_max_base;
    end
  end

  assign stat_n      = r_n;
  assign stat_nerr   = r_nerr;
  assign stat_sum_ed = r_sum;
  assign stat_max_ed = r_max;

`ifdef APPROX_ERR_HIST_EN
  logic [7:0][CNT_W-1:0] r_hist;
  logic [2:0]            w_bin;

  // bin = MSB index + 1, clamped to 7; ed==0 stays in bin 0
  always_comb begin
    w_bin = 3'd0;
    for (int i = 0; i <= W; i++)
      if (w_ed[i]) w_bin = (i >= 6) ? 3'd7 : 3'(i + 1);
  end

  // histogram bins follow the same clear/accept priority as the stats
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (w_xfer && (w_bin == 3'(j)))
          r_hist[j] <= CNT_W'(sat_inc(stat_clr ? 64'd0 : 64'(r_hist[j]), 64'd1, CNT_W));
        else if (stat_clr)
          r_hist[j] <= '0;
      end
    end
  end

  assign hist_cnt = r_hist[hist_sel];
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor (small counter widths so that
// saturation is reachable in a short run).
`timescale 1ns/1ps
module tb_approx_err_monitor;
  localparam int W     = 8;
  localparam int CNT_W = 8;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [W-1:0]     in_a, in_b;
  logic [W:0]       in_approx;
  logic             out_valid, out_ready;
  logic [W:0]       out_exact, out_ed;
  logic             out_err;
  logic             stat_clr;
  logic [CNT_W-1:0] stat_n, stat_nerr;
  logic [ACC_W-1:0] stat_sum_ed;
  logic [W:0]       stat_max_ed;
`ifdef APPROX_ERR_HIST_EN
  logic [2:0]       hist_sel;
  logic [CNT_W-1:0] hist_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  approx_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_approx   (in_approx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_exact   (out_exact),
    .out_ed      (out_ed),
    .out_err     (out_err),
    .stat_clr    (stat_clr),
    .stat_n      (stat_n),
    .stat_nerr   (stat_nerr),
    .stat_sum_ed (stat_sum_ed),
`ifdef APPROX_ERR_HIST_EN
    .hist_sel    (hist_sel),
    .hist_cnt    (hist_cnt),
`endif
    .stat_max_ed (stat_max_ed)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one-cycle accepted sample; called at edge+1, returns at edge+1
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
    in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic stats(input string tag, input int n, input int ne, input int s, input int mx);
    chk({tag, ".n"},    64'(stat_n),      64'(n));
    chk({tag, ".nerr"}, 64'(stat_nerr),   64'(ne));
    chk({tag, ".sum"},  64'(stat_sum_ed), 64'(s));
    chk({tag, ".max"},  64'(stat_max_ed), 64'(mx));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = '0;
    out_ready = 1'b1; stat_clr = 1'b0;
`ifdef APPROX_ERR_HIST_EN
    hist_sel = '0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst.ovld",  64'(out_valid), 64'd0);
    chk("rst.irdy",  64'(in_ready),  64'd1);
    chk("rst.exact", 64'(out_exact), 64'd0);
    stats("rst", 0, 0, 0, 0);

    // 1: exact match
    send(8'h03, 8'h03, 9'h006);
    chk("t1.ovld",  64'(out_valid), 64'd1);
    chk("t1.exact", 64'(out_exact), 64'h006);
    chk("t1.ed",    64'(out_ed),    64'h000);
    chk("t1.err",   64'(out_err),   64'd0);
    stats("t1", 1, 0, 0, 0);

    // 2: large error with carry-out
    send(8'hFF, 8'hFF, 9'h100);
    chk("t2.exact", 64'(out_exact), 64'h1FE);
    chk("t2.ed",    64'(out_ed),    64'h0FE);
    chk("t2.err",   64'(out_err),   64'd1);
    stats("t2", 2, 1, 'hFE, 'hFE);
    tick();
    chk("t2.drain", 64'(out_valid), 64'd0);

    // 3: backpressure
    out_ready = 1'b0;
    in_a = 8'h01; in_b = 8'h02; in_approx = 9'h004; in_valid = 1'b1;
    tick();
    chk("t3.acc.ovld", 64'(out_valid), 64'd1);
    chk("t3.acc.irdy", 64'(in_ready),  64'd0);
    in_a = 8'h10; in_b = 8'h20; in_approx = 9'h030;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3.hold.exact", 64'(out_exact), 64'h003);
      chk("t3.hold.ed",    64'(out_ed),    64'h001);
      chk("t3.hold.n",     64'(stat_n),    64'd3);
      chk("t3.hold.irdy",  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1; #1;
    chk("t3.irdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t3.next.exact", 64'(out_exact), 64'h030);
    chk("t3.next.ed",    64'(out_ed),    64'h000);
    chk("t3.next.ovld",  64'(out_valid), 64'd1);
    tick();
    chk("t3.end.ovld", 64'(out_valid), 64'd0);
    stats("t3", 4, 2, 'hFF, 'hFE);

    // 4: clear alone, then clear coincident with an ed=5 sample
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    stats("t4.clr", 0, 0, 0, 0);
    stat_clr = 1'b1;
    send(8'h0A, 8'h0A, 9'h019);
    stat_clr = 1'b0;
    chk("t4.ed", 64'(out_ed), 64'd5);
    stats("t4", 1, 1, 5, 5);

    // 6: histogram bins
`ifdef APPROX_ERR_HIST_EN
    hist_sel = 3'd3; #1;
    chk("t6.b3.pre", 64'(hist_cnt), 64'd1);
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    send(8'h00, 8'h00, 9'h000);
    send(8'h00, 8'h00, 9'h001);
    send(8'h00, 8'h00, 9'h003);
    send(8'h80, 8'h00, 9'h000);
    for (int i = 0; i < 8; i++) begin
      hist_sel = 3'(i); #1;
      chk($sformatf("t6.bin%0d", i), 64'(hist_cnt),
          (i == 0 || i == 1 || i == 2 || i == 7) ? 64'd1 : 64'd0);
    end
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hist_sel = 3'(i); #1;
      chk($sformatf("t6.clr%0d", i), 64'(hist_cnt), 64'd0);
    end
`endif

    // 5: saturation (ed = 0x1FE = 510 per sample)
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    for (int i = 0; i < 8; i++) send(8'hFF, 8'hFF, 9'h000);
    chk("t5.sum8", 64'(stat_sum_ed), 64'hFF0);
    send(8'hFF, 8'hFF, 9'h000);
    chk("t5.sum9", 64'(stat_sum_ed), 64'hFFF);
    for (int i = 9; i < 255; i++) send(8'hFF, 8'hFF, 9'h000);
    chk("t5.n255", 64'(stat_n), 64'hFF);
    send(8'hFF, 8'hFF, 9'h000);
    send(8'hFF, 8'hFF, 9'h000);
    stats("t5.sat", 'hFF, 'hFF, 'hFFF, 'h1FE);

    // reset mid-operation: held result and stats discarded
    out_ready = 1'b0;
    send(8'h01, 8'h01, 9'h000);
    chk("rm.ovld.pre", 64'(out_valid), 64'd1);
    rst = 1'b1; in_valid = 1'b1; in_a = 8'h05; in_b = 8'h05; in_approx = 9'h000;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rm.ovld", 64'(out_valid), 64'd0);
    chk("rm.irdy", 64'(in_ready),  64'd1);
    stats("rm", 0, 0, 0, 0);
    out_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
